// File: rtl/count_pool_arbiter.sv
// -----------------------------------------------------------------------------
// count_pool_arbiter
// Shares P bounded repetition counters among R counting-constraint states.
// A state requests a slot on constraint entry (start). Free slots are granted
// round-robin over requesters, lowest-index free slot first. The owning state's
// consecutive matches (inc) are counted. The slot is released on the first
// mismatch, or once the count can no longer satisfy the bounds.
// All state updates occur on the falling clock edge.
//
// Ports:
//   clk        in   clock (state updates on negedge)
//   rst        in   asynchronous active-low reset
//   en         in   global enable; 0 holds all state
//   start[R]   in   per-state counter request / restart
//   inc[R]     in   per-state character-class match
//   hit[R]     out  owned slot count is within bounds
//   alloc_fail[R] out one-cycle pulse: request denied, pool exhausted
//   slot_busy[P] out per-slot valid flag
//   pool_full  out  all slots valid
// -----------------------------------------------------------------------------
module count_pool_arbiter #(
   parameter int R  = 4,
   parameter int P  = 2,
   parameter int K  = 4,
   parameter int LO = 12,
   parameter int HI = 12,
   parameter int G  = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [R-1:0] start,
   input  logic [R-1:0] inc,
   output logic [R-1:0] hit,
   output logic [R-1:0] alloc_fail,
   output logic [P-1:0] slot_busy,
   output logic         pool_full
);

   localparam int          OW   = (R > 1) ? $clog2(R) : 1;
   localparam int unsigned RU   = R;
   localparam int unsigned PU   = P;
   localparam logic [K-1:0] LO_K = K'(LO);
   localparam logic [K-1:0] HI_K = K'(HI);

   logic [P-1:0]  r_valid;
   logic [OW-1:0] r_owner [P];
   logic [K-1:0]  r_cnt   [P];
   logic [OW-1:0] r_rr;
   logic [R-1:0]  r_fail;

   logic [P-1:0]  w_valid_nxt;
   logic [OW-1:0] w_owner_nxt [P];
   logic [K-1:0]  w_cnt_nxt   [P];
   logic [OW-1:0] w_rr_nxt;
   logic [R-1:0]  w_fail_nxt;
   logic [R-1:0]  w_owned;
   logic [P-1:0]  w_in_bounds;
   logic [P-1:0]  w_taken;
   logic [OW-1:0] w_idx;
   logic          w_found;

   // Per-slot bound check and per-state ownership, from registered state only.
   always_comb begin
      w_owned     = '0;
      w_in_bounds = '0;
      hit         = '0;
      for (int unsigned p = 0; p < PU; p++) begin
         if (G == 0)      w_in_bounds[p] = (r_cnt[p] <= HI_K);
         else if (G == 2) w_in_bounds[p] = (r_cnt[p] >= LO_K);
         else             w_in_bounds[p] = (r_cnt[p] >= LO_K) && (r_cnt[p] <= HI_K);
         if (r_valid[p]) begin
            w_owned[r_owner[p]] = 1'b1;
            if (w_in_bounds[p]) hit[r_owner[p]] = 1'b1;
         end
      end
   end

   // Next-state: owned slots first (restart / count / release), then
   // allocation of new requests against slots that were free before the edge.
   always_comb begin
      w_valid_nxt = r_valid;
      w_owner_nxt = r_owner;
      w_cnt_nxt   = r_cnt;
      w_rr_nxt    = r_rr;
      w_fail_nxt  = '0;
      w_taken     = r_valid;
      w_idx       = '0;
      w_found     = 1'b0;

      for (int unsigned p = 0; p < PU; p++) begin
         if (r_valid[p]) begin
            if (start[r_owner[p]]) begin
               w_cnt_nxt[p] = '0;
            end else if (inc[r_owner[p]]) begin
               if ((G == 2) || (r_cnt[p] < HI_K)) begin
                  if (r_cnt[p] != '1) w_cnt_nxt[p] = r_cnt[p] + 1'b1;
               end else begin
                  // Count passed HI: this run can never hit again.
                  w_valid_nxt[p] = 1'b0;
                  w_cnt_nxt[p]   = '0;
               end
            end else begin
               w_valid_nxt[p] = 1'b0;
               w_cnt_nxt[p]   = '0;
            end
         end
      end

      for (int unsigned k = 0; k < RU; k++) begin
         w_idx = OW'((32'(r_rr) + k) % RU);
         if (start[w_idx] && !w_owned[w_idx]) begin
            w_found = 1'b0;
            for (int unsigned p = 0; p < PU; p++) begin
               if (!w_found && !w_taken[p]) begin
                  w_taken[p]     = 1'b1;
                  w_valid_nxt[p] = 1'b1;
                  w_owner_nxt[p] = w_idx;
                  w_cnt_nxt[p]   = '0;
                  w_found        = 1'b1;
               end
            end
            // Later grants in service order overwrite, leaving last-grant + 1.
            if (w_found) w_rr_nxt = OW'((32'(w_idx) + 1) % RU);
            else         w_fail_nxt[w_idx] = 1'b1;
         end
      end
   end

   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         r_rr    <= '0;
         r_fail  <= '0;
         for (int unsigned p = 0; p < PU; p++) begin
            r_owner[p] <= '0;
            r_cnt[p]   <= '0;
         end
      end else if (en) begin
         r_valid <= w_valid_nxt;
         r_rr    <= w_rr_nxt;
         r_fail  <= w_fail_nxt;
         for (int unsigned p = 0; p < PU; p++) begin
            r_owner[p] <= w_owner_nxt[p];
            r_cnt[p]   <= w_cnt_nxt[p];
         end
      end
   end

   assign alloc_fail = r_fail;
   assign slot_busy  = r_valid;
   assign pool_full  = &r_valid;

endmodule
